// File: rtl/watch_pkg.sv
// watch_pkg: mode encodings, field limits and BCD helpers shared by the watch
// mode sequencer and the clock/stopwatch datapaths.
package watch_pkg;

   typedef enum logic [1:0] {
      MODE_CLOCK     = 2'd0,
      MODE_STOPWATCH = 2'd1,
      MODE_SET_HOUR  = 2'd2,
      MODE_SET_MIN   = 2'd3
   } mode_e;

   localparam logic [4:0] MAX_HOUR = 5'd23;
   localparam logic [5:0] MAX_MIN  = 6'd59;

   // Two BCD digits {tens, ones} to binary 0..99
   function automatic logic [6:0] bcd2_to_bin(input logic [7:0] bcd);
      return (7'(bcd[7:4]) * 7'd10) + 7'(bcd[3:0]);
   endfunction

   // Binary 0..99 to two BCD digits {tens, ones}
   function automatic logic [7:0] bin_to_bcd2(input logic [6:0] bin);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = 4'(bin / 7'd10);
      ones = 4'(bin % 7'd10);
      return {tens, ones};
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: accepts a new raw button level only after the raw input has
// disagreed with the accepted level for DEBOUNCE_CYC consecutive cycles, and
// reports each accepted rising edge as a one-cycle registered press.
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 20
) (
   input  logic CLK,
   input  logic RESET,
   input  logic RAW,
   output logic LEVEL,
   output logic PRESS
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_level_d;
   logic             r_press;
   logic             w_differs;
   logic             w_accept;

   assign w_differs = (RAW != r_level);
   assign w_accept  = w_differs && (r_cnt == CNT_W'(DEBOUNCE_CYC - 1));

   // Stability counter, accepted level and rising-edge press pulse
   always_ff @(posedge CLK) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (RESET) begin
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_press   <= 1'b0;
      end else begin
         r_level_d <= r_level;
         r_press   <= r_level & ~r_level_d;
         if (!w_differs) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_cnt   <= '0;
            r_level <= RAW;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign LEVEL = r_level;
   assign PRESS = r_press;

endmodule

// File: rtl/watch_mode_ctrl.sv
// watch_mode_ctrl: debounces the four watch buttons, sequences the
// CLOCK / STOPWATCH / SET_HOUR / SET_MIN modes, issues stopwatch and time-set
// commands, and selects the digits and blanking sent to the display.
module watch_mode_ctrl
   import watch_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 20,
   parameter int BLINK_HALF   = 50
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        TICK_100HZ,
   input  logic        BTN_MODE,
   input  logic        BTN_SEL,
   input  logic        BTN_INC,
   input  logic        BTN_SS,
   input  logic [15:0] CLK_DIGITS,
   input  logic [15:0] SW_DIGITS,
   output logic [1:0]  MODE,
   output logic        SW_ENABLE,
   output logic        SW_TOGGLE,
   output logic        SW_CLEAR,
   output logic        SET_LOAD,
   output logic [4:0]  SET_HOUR,
   output logic [5:0]  SET_MIN,
   output logic [15:0] DISP_DIGITS,
   output logic [3:0]  DISP_BLANK
);

   localparam int BLINK_PERIOD = 2 * BLINK_HALF;
   localparam int BLINK_W      = $clog2(BLINK_PERIOD);

   // Button bit positions inside w_raw / w_press
   localparam int B_MODE = 0;
   localparam int B_SEL  = 1;
   localparam int B_INC  = 2;
   localparam int B_SS   = 3;

   logic [3:0]         w_raw;
   logic [3:0]         w_press;
   logic               w_mode_p;
   logic               w_sel_p;
   logic               w_inc_p;
   logic               w_ss_p;

   mode_e              r_state;
   mode_e              w_next_state;
   logic               r_sw_run;
   logic               w_next_sw_run;
   logic               r_sw_enable;
   logic               r_sw_toggle;
   logic               w_sw_toggle;
   logic               r_sw_clear;
   logic               w_sw_clear;
   logic               r_set_load;
   logic               w_set_load;
   logic [4:0]         r_hour;
   logic [4:0]         w_next_hour;
   logic [5:0]         r_min;
   logic [5:0]         w_next_min;
   logic               w_inc_done;
   logic               w_next_in_set;
   logic               w_blink_clr;
   logic [BLINK_W-1:0] r_blink;
   logic [BLINK_W-1:0] w_next_blink;
   logic               w_blank_phase;

   assign w_raw = {BTN_SS, BTN_INC, BTN_SEL, BTN_MODE};

   for (genvar g = 0; g < 4; g++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYC(DEBOUNCE_CYC)
      ) u_debounce (
         .CLK  (CLK),
         .RESET(RESET),
         .RAW  (w_raw[g]),
         .LEVEL(),
         .PRESS(w_press[g])
      );
   end

   // MODE beats SEL beats INC/SS; losing presses are simply dropped
   assign w_mode_p = w_press[B_MODE];
   assign w_sel_p  = w_press[B_SEL] & ~w_press[B_MODE];
   assign w_inc_p  = w_press[B_INC] & ~w_press[B_MODE] & ~w_press[B_SEL];
   assign w_ss_p   = w_press[B_SS]  & ~w_press[B_MODE] & ~w_press[B_SEL];

   // State register plus all registered outputs and shadow time
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state     <= MODE_CLOCK;
         r_sw_run    <= 1'b0;
         r_sw_enable <= 1'b0;
         r_sw_toggle <= 1'b0;
         r_sw_clear  <= 1'b0;
         r_set_load  <= 1'b0;
         r_hour      <= '0;
         r_min       <= '0;
         r_blink     <= '0;
      end else begin
         r_state     <= w_next_state;
         r_sw_run    <= w_next_sw_run;
         r_sw_enable <= (w_next_state == MODE_STOPWATCH);
         r_sw_toggle <= w_sw_toggle;
         r_sw_clear  <= w_sw_clear;
         r_set_load  <= w_set_load;
         r_hour      <= w_next_hour;
         r_min       <= w_next_min;
         r_blink     <= w_next_blink;
      end
   end

   // Next state, command pulses, shadow time edits and blink counter
   always_comb begin
      // NOTE: every signal gets a default before the case so no path can
      // leave one unassigned and infer a latch.
      w_next_state  = r_state;
      w_next_sw_run = r_sw_run;
      w_next_hour   = r_hour;
      w_next_min    = r_min;
      w_sw_toggle   = 1'b0;
      w_sw_clear    = 1'b0;
      w_set_load    = 1'b0;
      w_inc_done    = 1'b0;

      case (r_state)
         MODE_CLOCK: begin
            if (w_mode_p) w_next_state = MODE_STOPWATCH;
         end
         MODE_STOPWATCH: begin
            if (w_mode_p) begin
               w_next_state = MODE_SET_HOUR;
               w_next_hour  = 5'(bcd2_to_bin(CLK_DIGITS[15:8]));
               w_next_min   = 6'(bcd2_to_bin(CLK_DIGITS[7:0]));
            end else if (w_sel_p) begin
               w_sw_clear = ~r_sw_run;
            end else if (w_ss_p) begin
               w_sw_toggle   = 1'b1;
               w_next_sw_run = ~r_sw_run;
            end
         end
         MODE_SET_HOUR: begin
            if (w_mode_p) begin
               w_next_state = MODE_CLOCK;
            end else if (w_sel_p) begin
               w_next_state = MODE_SET_MIN;
            end else if (w_inc_p) begin
               w_next_hour = (r_hour >= MAX_HOUR) ? 5'd0 : r_hour + 5'd1;
               w_inc_done  = 1'b1;
            end
         end
         MODE_SET_MIN: begin
            if (w_mode_p) begin
               w_next_state = MODE_CLOCK;
            end else if (w_sel_p) begin
               w_next_state = MODE_CLOCK;
               w_set_load   = 1'b1;
            end else if (w_inc_p) begin
               w_next_min = (r_min >= MAX_MIN) ? 6'd0 : r_min + 6'd1;
               w_inc_done = 1'b1;
            end
         end
         default: w_next_state = MODE_CLOCK;
      endcase

      // The run flag only has meaning while the stopwatch is selected
      if (w_next_state != MODE_STOPWATCH) w_next_sw_run = 1'b0;

      // Restart the blink period whenever the edited field changes or appears
      w_next_in_set = (w_next_state == MODE_SET_HOUR) || (w_next_state == MODE_SET_MIN);
      w_blink_clr   = !w_next_in_set || (w_next_state != r_state) || w_inc_done;
      if (w_blink_clr) begin
         w_next_blink = '0;
      end else if (TICK_100HZ) begin
         w_next_blink = (r_blink == BLINK_W'(BLINK_PERIOD - 1)) ? '0 : r_blink + 1'b1;
      end else begin
         w_next_blink = r_blink;
      end
   end

   assign w_blank_phase = (r_blink >= BLINK_W'(BLINK_HALF));

   // Display digit select and per-field blanking
   always_comb begin
      DISP_DIGITS = CLK_DIGITS;
      DISP_BLANK  = 4'b0000;
      case (r_state)
         MODE_CLOCK:     DISP_DIGITS = CLK_DIGITS;
         MODE_STOPWATCH: DISP_DIGITS = SW_DIGITS;
         MODE_SET_HOUR: begin
            DISP_DIGITS = {bin_to_bcd2(7'(r_hour)), bin_to_bcd2(7'(r_min))};
            DISP_BLANK  = w_blank_phase ? 4'b1100 : 4'b0000;
         end
         MODE_SET_MIN: begin
            DISP_DIGITS = {bin_to_bcd2(7'(r_hour)), bin_to_bcd2(7'(r_min))};
            DISP_BLANK  = w_blank_phase ? 4'b0011 : 4'b0000;
         end
         default: DISP_DIGITS = CLK_DIGITS;
      endcase
   end

   assign MODE      = r_state;
   assign SW_ENABLE = r_sw_enable;
   assign SW_TOGGLE = r_sw_toggle;
   assign SW_CLEAR  = r_sw_clear;
   assign SET_LOAD  = r_set_load;
   assign SET_HOUR  = r_hour;
   assign SET_MIN   = r_min;

endmodule
